// File: rtl/store_buffer.sv
// store_buffer: in-order FIFO of pending stores between the EX/MEM stage
// and a single-ported data memory. Loads get priority on the memory port
// unless the buffer is full, and read their data from the youngest
// buffered store to the same word address when one exists.
//
// Handshake: a store (load) transfers in a cycle where st_valid && st_ready
// (ld_valid && ld_ready); the ready signals depend only on registered state,
// never on the valid inputs, so a producer may hold valid until it sees ready.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  output logic        ld_ready,
  output logic [31:0] ld_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata,
  output logic        empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [31:0]   addr_q [DEPTH];
  logic [31:0]   addr_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  logic          full;
  logic          push;
  logic          pop;
  logic [PW-1:0] fwd_idx;

  // Handshake flags and memory-port arbitration: full buffer drains first,
  // then a waiting load, then any pending store.
  always_comb begin
    full      = (count_q == DEPTH_C);
    st_ready  = !full;
    ld_ready  = !full;
    empty     = (count_q == '0);
    push      = st_valid && st_ready;
    pop       = full || (!ld_valid && !empty);
    mem_we    = pop;
    mem_addr  = pop ? addr_q[head_q] : ld_addr;
    mem_wdata = pop ? data_q[head_q] : 32'h0;
  end

  // Load forwarding: scan oldest to youngest so the youngest match wins;
  // only entries already present this cycle are candidates.
  always_comb begin
    ld_data = mem_rdata;
    fwd_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if (((PW+1)'(i) < count_q) && (addr_q[fwd_idx] == ld_addr)) begin
        ld_data = data_q[fwd_idx];
      end
    end
  end

  // Next-state: write at tail on push, advance head on pop; pointers wrap
  // naturally because DEPTH is a power of two.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      addr_d[tail_q] = st_addr;
      data_d[tail_q] = st_data;
      tail_d         = tail_q + PW'(1);
    end
    if (pop) begin
      head_d = head_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + (PW+1)'(1);
    end else if (!push && pop) begin
      count_d = count_q - (PW+1)'(1);
    end
  end

  // State registers; reset discards every pending store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer (DEPTH = 4).
module tb_store_buffer;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        empty;

  int errors;
  int checks;

  store_buffer #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_ready  (st_ready),
    .ld_valid  (ld_valid),
    .ld_addr   (ld_addr),
    .ld_ready  (ld_ready),
    .ld_data   (ld_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .empty     (empty)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Commit the current inputs at the next rising edge, then leave 1ns so
  // the following input changes land away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_st(input logic v, input logic [31:0] a, input logic [31:0] d);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic drive_ld(input logic v, input logic [31:0] a, input logic [31:0] rd);
    ld_valid  = v;
    ld_addr   = a;
    mem_rdata = rd;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;
    drive_st(1'b0, 32'h0, 32'h0);
    drive_ld(1'b0, 32'h1234_5678, 32'h0);

    // Reset values
    #12;
    chk("rst_st_ready", {31'h0, st_ready}, 32'd1);
    chk("rst_ld_ready", {31'h0, ld_ready}, 32'd1);
    chk("rst_empty",    {31'h0, empty},    32'd1);
    chk("rst_mem_we",   {31'h0, mem_we},   32'd0);
    chk("rst_wdata",    mem_wdata,         32'h0);
    chk("rst_mem_addr", mem_addr,          32'h1234_5678);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Miss path on an empty buffer
    drive_ld(1'b1, 32'h0010_0000, 32'hCAFE_0000);
    #1;
    chk("miss_ld_data",  ld_data,            32'hCAFE_0000);
    chk("miss_ld_ready", {31'h0, ld_ready},  32'd1);
    chk("miss_mem_we",   {31'h0, mem_we},    32'd0);
    chk("miss_mem_addr", mem_addr,           32'h0010_0000);
    tick();
    drive_ld(1'b0, 32'h0, 32'h0);

    // Single store drains on the next cycle
    drive_st(1'b1, 32'h0010_0000, 32'hDEAD_BEEF);
    #1;
    chk("single_st_ready", {31'h0, st_ready}, 32'd1);
    chk("single_we0",      {31'h0, mem_we},   32'd0);
    tick();
    drive_st(1'b0, 32'h0, 32'h0);
    #1;
    chk("single_we1",    {31'h0, mem_we}, 32'd1);
    chk("single_addr",   mem_addr,        32'h0010_0000);
    chk("single_wdata",  mem_wdata,       32'hDEAD_BEEF);
    chk("single_empty0", {31'h0, empty},  32'd0);
    tick();
    chk("single_empty1", {31'h0, empty},  32'd1);
    chk("single_we_off", {31'h0, mem_we}, 32'd0);

    // Forwarding: youngest match wins, same-cycle store not forwarded
    drive_ld(1'b1, 32'h0010_0004, 32'h0000_0099);
    drive_st(1'b1, 32'h0010_0004, 32'h0000_0011);
    #1;
    chk("fwd_same_cycle", ld_data, 32'h0000_0099);
    tick();
    drive_st(1'b1, 32'h0010_0004, 32'h0000_0022);
    #1;
    chk("fwd_one_entry", ld_data,          32'h0000_0011);
    chk("fwd_ld_prio",   {31'h0, mem_we},  32'd0);
    tick();
    drive_st(1'b0, 32'h0, 32'h0);
    #1;
    chk("fwd_youngest", ld_data, 32'h0000_0022);
    ld_addr = 32'h0010_0008;
    #1;
    chk("fwd_other_addr", ld_data, 32'h0000_0099);
    tick();
    drive_ld(1'b0, 32'h0, 32'h0);
    #1;
    chk("order_we_a",   {31'h0, mem_we}, 32'd1);
    chk("order_addr_a", mem_addr,        32'h0010_0004);
    chk("order_data_a", mem_wdata,       32'h0000_0011);
    tick();
    chk("order_data_b", mem_wdata,       32'h0000_0022);
    chk("order_we_b",   {31'h0, mem_we}, 32'd1);
    tick();
    chk("order_empty",  {31'h0, empty},  32'd1);

    // Fill with a load holding the port, then one forced drain cycle
    drive_ld(1'b1, 32'h0010_0000, 32'h0000_0055);
    for (int k = 0; k < 4; k++) begin
      drive_st(1'b1, 32'h0020_0000 + 32'(4 * k), 32'h0000_00A0 + 32'(k));
      #1;
      chk("fill_st_ready", {31'h0, st_ready}, 32'd1);
      chk("fill_we",       {31'h0, mem_we},   32'd0);
      tick();
    end
    drive_st(1'b0, 32'h0, 32'h0);
    #1;
    chk("full_st_ready", {31'h0, st_ready}, 32'd0);
    chk("full_ld_ready", {31'h0, ld_ready}, 32'd0);
    chk("full_we",       {31'h0, mem_we},   32'd1);
    chk("full_addr",     mem_addr,          32'h0020_0000);
    chk("full_wdata",    mem_wdata,         32'h0000_00A0);
    tick();
    chk("after_full_ld_ready", {31'h0, ld_ready}, 32'd1);
    chk("after_full_st_ready", {31'h0, st_ready}, 32'd1);
    chk("after_full_we",       {31'h0, mem_we},   32'd0);
    chk("after_full_ld_data",  ld_data,           32'h0000_0055);
    tick();

    // Push plus pop on a drain cycle keeps the count
    drive_ld(1'b0, 32'h0, 32'h0);
    #1;
    chk("pp_drain_a1", mem_wdata, 32'h0000_00A1);
    tick();
    drive_st(1'b1, 32'h0030_0000, 32'h0000_0077);
    #1;
    chk("pp_drain_a2",  mem_wdata,         32'h0000_00A2);
    chk("pp_st_ready",  {31'h0, st_ready}, 32'd1);
    tick();
    drive_st(1'b0, 32'h0, 32'h0);
    #1;
    chk("pp_drain_a3", mem_wdata,      32'h0000_00A3);
    chk("pp_not_empty", {31'h0, empty}, 32'd0);
    tick();
    chk("pp_drain_x_data", mem_wdata, 32'h0000_0077);
    chk("pp_drain_x_addr", mem_addr,  32'h0030_0000);
    tick();
    chk("pp_empty", {31'h0, empty},  32'd1);
    chk("pp_we",    {31'h0, mem_we}, 32'd0);

    // Reset mid-run discards pending stores
    drive_ld(1'b1, 32'h0000_0000, 32'h0);
    for (int k = 0; k < 3; k++) begin
      drive_st(1'b1, 32'h0040_0000 + 32'(4 * k), 32'h0000_00B0 + 32'(k));
      tick();
    end
    drive_st(1'b0, 32'h0, 32'h0);
    drive_ld(1'b0, 32'h0040_0000, 32'h0000_0EEE);
    #1;
    chk("pre_rst_we", {31'h0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we",    {31'h0, mem_we}, 32'd0);
    chk("mid_rst_empty", {31'h0, empty},  32'd1);
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_empty",   {31'h0, empty},  32'd1);
    chk("post_rst_we",      {31'h0, mem_we}, 32'd0);
    chk("post_rst_ld_data", ld_data,         32'h0000_0EEE);
    tick();
    chk("post_rst_we2", {31'h0, mem_we}, 32'd0);
    drive_st(1'b1, 32'h0050_0000, 32'h0000_00C0);
    tick();
    drive_st(1'b0, 32'h0, 32'h0);
    #1;
    chk("first_drain_we",    {31'h0, mem_we}, 32'd1);
    chk("first_drain_addr",  mem_addr,        32'h0050_0000);
    chk("first_drain_wdata", mem_wdata,       32'h0000_00C0);
    tick();
    chk("final_empty", {31'h0, empty}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
